// File: rtl/datamem_pkg.sv
// Shared definitions for the byte-wide data memory controller.
//   MEM_DEPTH_DEF : default number of byte locations in the attached datamem
//   F3_*          : RISC-V load/store size codes (funct3)
//   S_*           : controller FSM state encodings
//   dec_t         : decoded request (byte count, sign-extend flag, error flag)
package datamem_pkg;

  localparam int MEM_DEPTH_DEF = 4096;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [2:0] nbytes;  // 1, 2 or 4
    logic       sign;    // sign-extend load result
    logic       err;     // request must be rejected
  } dec_t;

endpackage

// File: rtl/datamem_ctrl_decode.sv
// Combinational request decoder.
//   we, funct3, addr : raw request fields
//   dec              : byte count, sign flag, error flag (bad code, store with
//                      unsigned code, misalignment, or access past MEM_DEPTH-1)
module datamem_ctrl_decode
  import datamem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output dec_t        dec
);

  localparam logic [32:0] DEPTH33 = 33'(MEM_DEPTH);

  logic        bad_code;
  logic        misalign;
  logic [32:0] last_byte;

  always_comb begin
    dec      = '0;
    bad_code = 1'b0;
    dec.nbytes = 3'd1;
    case (funct3)
      F3_B:    dec.sign = 1'b1;
      F3_H:    begin dec.nbytes = 3'd2; dec.sign = 1'b1; end
      F3_W:    dec.nbytes = 3'd4;
      F3_BU:   bad_code = we;
      F3_HU:   begin dec.nbytes = 3'd2; bad_code = we; end
      default: bad_code = 1'b1;
    endcase
    misalign = ((dec.nbytes == 3'd2) && addr[0]) ||
               ((dec.nbytes == 3'd4) && (addr[1:0] != 2'b00));
    // 33-bit sum so an address near 2^32 cannot wrap into range
    last_byte = {1'b0, addr} + {30'b0, dec.nbytes} - 33'd1;
    dec.err   = bad_code || misalign || (last_byte >= DEPTH33);
  end

endmodule

// File: rtl/datamem_ctrl.sv
// Load/store controller for a byte-wide datamem.
//   clk, rst                      : clock, async active-high reset
//   req_valid/ready/we/funct3/addr/wdata : request handshake and fields
//   rsp_valid/rdata/err           : one-cycle completion pulse
//   mem_address/data_in/write_en  : byte interface to datamem
//   mem_data_out                  : read byte, valid one cycle after address
// A request moves one byte per cycle in XFER. Loads need one extra DRAIN cycle
// because the last read byte arrives a cycle after its address.
module datamem_ctrl
  import datamem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_out
);

  dec_t        dec;
  logic [1:0]  state;
  logic [1:0]  cnt;     // byte index being driven in XFER
  logic [1:0]  last;    // index of final byte (N-1)
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic        sign_q;
  logic        err_q;
  logic        in_xfer;

  datamem_ctrl_decode #(.MEM_DEPTH(MEM_DEPTH)) u_dec (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .dec    (dec)
  );

  // rst term makes req_ready drop the instant reset is applied
  assign req_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          we_q    <= req_we;
          sign_q  <= dec.sign;
          err_q   <= dec.err;
          last    <= 2'(dec.nbytes - 3'd1);
          cnt     <= '0;
          rdata_q <= '0;
          state   <= dec.err ? S_RESP : S_XFER;
        end
        S_XFER: begin
          // byte cnt-1 was addressed last cycle and is on mem_data_out now
          if (!we_q && (cnt != 2'd0))
            rdata_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_data_out;
          if (cnt == last) state <= we_q ? S_RESP : S_DRAIN;
          else             cnt   <= cnt + 2'd1;
        end
        S_DRAIN: begin
          rdata_q[{cnt, 3'b000} +: 8] <= mem_data_out;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_xfer      = (state == S_XFER);
  assign mem_address  = in_xfer ? addr_q + {30'b0, cnt} : '0;
  assign mem_data_in  = in_xfer ? wdata_q[{cnt, 3'b000} +: 8] : '0;
  assign mem_write_en = in_xfer && we_q;

  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = rsp_valid && err_q;

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !err_q && !we_q) begin
      case (last)
        2'd0:    rsp_rdata = {{24{sign_q & rdata_q[7]}},  rdata_q[7:0]};
        2'd1:    rsp_rdata = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
        default: rsp_rdata = rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed bench for datamem_ctrl with a byte memory model and a response
// scoreboard (expected error/data/latency queued at drive, popped at rsp_valid).
module tb_datamem_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [7:0]  mem_data_in;
  logic        mem_write_en;
  logic [7:0]  mem_data_out = '0;

  int n_run  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  datamem_ctrl #(.MEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  // Byte memory model: synchronous write, registered read.
  logic [7:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_address < DEPTH) begin
      if (mem_write_en) mem[int'(mem_address)] <= mem_data_in;
      mem_data_out <= mem[int'(mem_address)];
    end
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then follow it to its response. elat is the cycle
  // (counted from the acceptance edge) in which rsp_valid must appear.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic eerr, input logic [31:0] erd,
                        input int elat, input string tag);
    int   k;
    int   lat;
    int   wr0;
    exp_t e;
    wr0 = wr_cnt;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    sb.push_back('{eerr, erd, elat});
    @(negedge clk);
    // scramble request fields: the controller must use its latched copy
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_busy_rdy"}, 32'(req_ready), 32'd0);
      if (we && !eerr && lat <= elat - 1) begin
        check({tag, "_we"},   32'(mem_write_en), 32'd1);
        check({tag, "_addr"}, mem_address, addr + 32'(lat - 1));
        check({tag, "_wdat"}, 32'(mem_data_in), 32'(wdata[8*(lat-1) +: 8]));
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"},   32'(lat), 32'(e.lat));
      check({tag, "_err"},   32'(rsp_err), 32'(e.err));
      check({tag, "_rdata"}, rsp_rdata, e.rd);
    end
    if (eerr) check({tag, "_nowrite"}, 32'(wr_cnt - wr0), 32'd0);
  endtask

  initial begin
    int wr0;
    exp_t e;

    // reset values while rst is held
    #1;
    check("rst_ready", 32'(req_ready),    32'd0);
    check("rst_rspv",  32'(rsp_valid),    32'd0);
    check("rst_err",   32'(rsp_err),      32'd0);
    check("rst_rdata", rsp_rdata,         32'd0);
    check("rst_we",    32'(mem_write_en), 32'd0);
    check("rst_addr",  mem_address,       32'd0);
    check("rst_din",   32'(mem_data_in),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_ready", 32'(req_ready), 32'd1);

    // store then loads of every width
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 5, "sw100");
    check("m100", 32'(mem[32'h100]), 32'hEF);
    check("m101", 32'(mem[32'h101]), 32'hBE);
    check("m102", 32'(mem[32'h102]), 32'hAD);
    check("m103", 32'(mem[32'h103]), 32'hDE);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 6, "lw100");
    do_req(1'b0, 3'b000, 32'h102, 32'h0, 1'b0, 32'hFFFFFFAD, 3, "lb102");
    do_req(1'b0, 3'b100, 32'h102, 32'h0, 1'b0, 32'h000000AD, 3, "lbu102");
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'hFFFFDEAD, 4, "lh102");
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 1'b0, 32'h0000BEEF, 4, "lhu100");
    do_req(1'b1, 3'b001, 32'h300, 32'hAAAA8001, 1'b0, 32'h0, 3, "sh300");
    do_req(1'b0, 3'b001, 32'h300, 32'h0, 1'b0, 32'hFFFF8001, 4, "lh300");
    do_req(1'b0, 3'b101, 32'h300, 32'h0, 1'b0, 32'h00008001, 4, "lhu300");
    check("m302", 32'(mem[32'h302]), 32'h00);

    // top-of-memory boundary, legal side
    do_req(1'b1, 3'b010, 32'hFFC, 32'h01020304, 1'b0, 32'h0, 5, "swFFC");
    do_req(1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, 32'h01020304, 6, "lwFFC");
    do_req(1'b0, 3'b000, 32'hFFF, 32'h0, 1'b0, 32'h00000001, 3, "lbFFF");

    // rejected requests
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 1'b0 | 1'b1, 32'h0, 1, "lw101");
    do_req(1'b1, 3'b010, 32'hFFE, 32'h55555555, 1'b1, 32'h0, 1, "swFFE");
    do_req(1'b1, 3'b100, 32'h010, 32'h12345678, 1'b1, 32'h0, 1, "sbu");
    do_req(1'b0, 3'b011, 32'h000, 32'h0, 1'b1, 32'h0, 1, "f3_011");
    do_req(1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0, 1, "lh101");
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 32'h0, 1, "lw1000");
    do_req(1'b1, 3'b000, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1, "sb_wrap");

    // reset in the middle of a store
    wr0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    check("rs_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rs_we",    32'(mem_write_en), 32'd0);
    check("rs_addr",  mem_address,       32'd0);
    check("rs_rdy",   32'(req_ready),    32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rs_norsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rs_relrdy", 32'(req_ready), 32'd1);
    check("rs_relrsp", 32'(rsp_valid), 32'd0);
    check("rs_m200",  32'(mem[32'h200]), 32'h44);
    check("rs_m201",  32'(mem[32'h201]), 32'h33);
    check("rs_m202",  32'(mem[32'h202]), 32'h00);
    check("rs_m203",  32'(mem[32'h203]), 32'h00);
    check("rs_nwr",   32'(wr_cnt - wr0), 32'd2);

    // held req_valid: SB then LBU back to back
    wr0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0000005A;
    req_valid = 1'b1;
    check("bb_ready0", 32'(req_ready), 32'd1);
    sb.push_back('{1'b0, 32'h0, 2});
    sb.push_back('{1'b0, 32'h0000005A, 6});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
      end
      check($sformatf("bb_rdy%0d", k), 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("bb_rspv%0d", k), 32'(rsp_valid), (k == 2 || k == 6) ? 32'd1 : 32'd0);
      if (rsp_valid && sb.size() > 0) begin
        e = sb.pop_front();
        check("bb_lat",   32'(k), 32'(e.lat));
        check("bb_err",   32'(rsp_err), 32'(e.err));
        check("bb_rdata", rsp_rdata, e.rd);
      end
      if (k == 4) req_valid = 1'b0;
    end
    check("bb_sb_empty", 32'(sb.size()), 32'd0);
    check("bb_m10",  32'(mem[32'h10]), 32'h5A);
    check("bb_nwr",  32'(wr_cnt - wr0), 32'd1);
    @(negedge clk);
    check("bb_idle", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
